// File: rtl/inta_sequencer.sv
// Purpose : CPU-side 8259 PIC initiator: syncs INT, runs the two-pulse INTA_n
//           sequence, captures the vector and issues OCW2 EOI writes.
// Latency : INT rise -> INTA_n fall in 3 edges; vector valid on the edge ending pulse 2.
// Backpr. : vector held in HOLD until vector_ready; eoi_ready low whenever not IDLE.
// Ports   : clk/rst_n; INT, int_en, data_in (PIC side in); vector/vector_valid/
//           vector_ready (core vector handshake); eoi_valid/eoi_specific/eoi_level/
//           eoi_ready (core EOI handshake); INTA_n, WR_n, A0, data_out, data_oe
//           (PIC strobes and bus); busy (FSM not idle).
module inta_sequencer #(
  parameter int INTA_LOW = 2,
  parameter int INTA_GAP = 2,
  parameter int WR_LOW   = 2,
  parameter int RECOVER  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       int_en,
  input  logic [7:0] data_in,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       eoi_ready,
  output logic       INTA_n,
  output logic       WR_n,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy
);

  localparam int MAX_AB = (INTA_LOW > INTA_GAP) ? INTA_LOW : INTA_GAP;
  localparam int MAX_CD = (WR_LOW > RECOVER) ? WR_LOW : RECOVER;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INTA1  = 3'd1,
    GAP    = 3'd2,
    INTA2  = 3'd3,
    HOLD   = 3'd4,
    EOI_WR = 3'd5,
    REC    = 3'd6
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt_load;
  logic            r_int_meta, r_int_s;
  logic            r_inta_n, w_inta_n;
  logic            r_wr_n, w_wr_n;
  logic            r_data_oe, w_data_oe;
  logic [7:0]      r_data_out, w_data_out;
  logic [7:0]      r_vector, w_vector;
  logic            r_vector_valid, w_vector_valid;
  logic            r_eoi_ready;
  logic            r_busy;
  logic            w_cnt_done;

  assign w_cnt_done = (r_cnt == '0);

  // Two-flop synchroniser for the asynchronous INT line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
    end
  end

  // Next state and next registered output values.
  always_comb begin
    w_next         = r_state;
    w_inta_n       = r_inta_n;
    w_wr_n         = r_wr_n;
    w_data_oe      = r_data_oe;
    w_data_out     = r_data_out;
    w_vector       = r_vector;
    w_vector_valid = r_vector_valid;
    w_cnt_load     = '0;
    case (r_state)
      IDLE: begin
        // EOI wins over a pending interrupt in the same cycle.
        if (eoi_valid && r_eoi_ready) begin
          w_next     = EOI_WR;
          w_wr_n     = 1'b0;
          w_data_oe  = 1'b1;
          w_data_out = eoi_specific ? {5'b01100, eoi_level} : 8'h20;
        end else if (r_int_s && int_en) begin
          w_next   = INTA1;
          w_inta_n = 1'b0;
        end
      end
      INTA1: if (w_cnt_done) begin
        w_next   = GAP;
        w_inta_n = 1'b1;
      end
      GAP: if (w_cnt_done) begin
        w_next   = INTA2;
        w_inta_n = 1'b0;
      end
      INTA2: if (w_cnt_done) begin
        w_next         = HOLD;
        w_inta_n       = 1'b1;
        w_vector       = data_in;
        w_vector_valid = 1'b1;
      end
      HOLD: if (vector_ready) begin
        w_next         = REC;
        w_vector_valid = 1'b0;
      end
      EOI_WR: if (w_cnt_done) begin
        w_next    = REC;
        w_wr_n    = 1'b1;
        w_data_oe = 1'b0;
      end
      REC: if (w_cnt_done) w_next = IDLE;
      default: begin
        w_next    = IDLE;
        w_inta_n  = 1'b1;
        w_wr_n    = 1'b1;
        w_data_oe = 1'b0;
      end
    endcase
    // Counter holds (cycles remaining - 1) for the state being entered.
    case (w_next)
      INTA1, INTA2: w_cnt_load = CW'(INTA_LOW - 1);
      GAP:          w_cnt_load = CW'(INTA_GAP - 1);
      EOI_WR:       w_cnt_load = CW'(WR_LOW - 1);
      REC:          w_cnt_load = CW'(RECOVER - 1);
      default:      w_cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_inta_n       <= 1'b1;
      r_wr_n         <= 1'b1;
      r_data_oe      <= 1'b0;
      r_data_out     <= 8'h00;
      r_vector       <= 8'h00;
      r_vector_valid <= 1'b0;
      r_eoi_ready    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_inta_n       <= w_inta_n;
      r_wr_n         <= w_wr_n;
      r_data_oe      <= w_data_oe;
      r_data_out     <= w_data_out;
      r_vector       <= w_vector;
      r_vector_valid <= w_vector_valid;
      r_eoi_ready    <= (w_next == IDLE);
      r_busy         <= (w_next != IDLE);
      if (w_next != r_state) r_cnt <= w_cnt_load;
      else if (!w_cnt_done)  r_cnt <= r_cnt - CW'(1);
    end
  end

  assign INTA_n       = r_inta_n;
  assign WR_n         = r_wr_n;
  assign A0           = 1'b0;  // only OCW2 is ever written
  assign data_oe      = r_data_oe;
  assign data_out     = r_data_out;
  assign vector       = r_vector;
  assign vector_valid = r_vector_valid;
  assign eoi_ready    = r_eoi_ready;
  assign busy         = r_busy;

endmodule

// File: tb/tb_inta_sequencer.sv
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       INT = 1'b0;
  logic       int_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] vector;
  logic       vector_valid;
  logic       vector_ready = 1'b0;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       eoi_ready;
  logic       INTA_n;
  logic       WR_n;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;

  int checks = 0;
  int failures = 0;

  inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .int_en(int_en), .data_in(data_in),
    .vector(vector), .vector_valid(vector_valid), .vector_ready(vector_ready),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .eoi_ready(eoi_ready), .INTA_n(INTA_n), .WR_n(WR_n), .A0(A0),
    .data_out(data_out), .data_oe(data_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inta(input logic v, input string nm);
    int n = 0;
    while (INTA_n !== v && n < 50) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, INTA_n}, {31'd0, v});
  endtask

  // Let any in-flight sequence finish and the FSM settle in IDLE.
  task automatic drain(input string nm);
    int idle_run = 0;
    int n = 0;
    INT = 1'b0;
    eoi_valid = 1'b0;
    vector_ready = 1'b1;
    while (idle_run < 6 && n < 300) begin
      tick();
      n++;
      if (busy === 1'b0) idle_run++;
      else idle_run = 0;
    end
    chk(nm, {31'd0, busy}, 32'd0);
    vector_ready = 1'b0;
  endtask

  // ---------------- transaction-level protocol monitor ----------------
  bit         mon_en = 1'b0;
  bit         eoi_taken = 1'b0;
  int         inta_run = 0, gap_run = 0, pulse_no = 0, wr_run = 0;
  int         n_vec = 0, n_eoi = 0;
  logic [7:0] last_d;
  logic [7:0] cur_eoi;
  logic [7:0] exp_vec_q[$];
  logic [7:0] exp_eoi_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      // INTA pulses come in pairs; the vector is whatever the PIC drove in the
      // final low cycle of the second pulse.
      if (INTA_n === 1'b0) begin
        if (inta_run == 0 && pulse_no == 1) chk("mon_inta_gap", gap_run, 2);
        inta_run++;
        last_d = data_in;
      end else if (inta_run > 0) begin
        chk("mon_inta_width", inta_run, 2);
        if (pulse_no == 0) begin
          pulse_no = 1;
          gap_run = 1;
        end else begin
          pulse_no = 0;
          exp_vec_q.push_back(last_d);
        end
        inta_run = 0;
      end else if (pulse_no == 1) begin
        gap_run++;
      end
      if (vector_valid === 1'b1 && vector_ready === 1'b1) begin
        if (exp_vec_q.size() == 0) chk("mon_vec_unexpected", 32'd1, 32'd0);
        else chk("mon_vector", {24'd0, vector}, {24'd0, exp_vec_q.pop_front()});
        n_vec++;
      end
      // EOI requests are remembered at the handshake and matched to WR_n pulses.
      if (eoi_valid === 1'b1 && eoi_ready === 1'b1) begin
        exp_eoi_q.push_back(eoi_specific ? {5'b01100, eoi_level} : 8'h20);
        eoi_taken = 1'b1;
      end
      if (WR_n === 1'b0) begin
        if (wr_run == 0) begin
          if (exp_eoi_q.size() == 0) begin
            chk("mon_wr_unexpected", 32'd1, 32'd0);
            cur_eoi = 8'hxx;
          end else cur_eoi = exp_eoi_q.pop_front();
          chk("mon_eoi_byte", {24'd0, data_out}, {24'd0, cur_eoi});
          chk("mon_eoi_a0_oe", {30'd0, A0, data_oe}, 32'd1);
          n_eoi++;
        end
        wr_run++;
      end else if (wr_run > 0) begin
        chk("mon_wr_width", wr_run, 2);
        chk("mon_oe_off", {31'd0, data_oe}, 32'd0);
        wr_run = 0;
      end
      if (INTA_n === 1'b0 && WR_n === 1'b0) chk("mon_strobe_overlap", 32'd1, 32'd0);
    end
  end

  typedef struct {
    logic       spec;
    logic [2:0] lvl;
    logic [7:0] exp_dat;
  } eoi_vec_t;

  eoi_vec_t tbl[5];

  initial begin
    int expl [1:10];
    tbl[0] = '{1'b0, 3'd0, 8'h20};
    tbl[1] = '{1'b1, 3'd3, 8'h63};
    tbl[2] = '{1'b1, 3'd0, 8'h60};
    tbl[3] = '{1'b1, 3'd7, 8'h67};
    tbl[4] = '{1'b0, 3'd5, 8'h20};
    for (int e = 1; e <= 10; e++) expl[e] = (e == 3 || e == 4 || e == 7 || e == 8) ? 0 : 1;

    // ---------------- reset state ----------------
    #2 rst_n = 1'b0;
    #10;
    chk("rst_strobes", {28'd0, INTA_n, WR_n, A0, data_oe}, 32'b1100);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_vector", {23'd0, vector, vector_valid}, 32'd0);
    chk("rst_ready_busy", {30'd0, eoi_ready, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("eoi_ready_after_rst", {31'd0, eoi_ready}, 32'd1);

    // ---------------- basic two-pulse acknowledge ----------------
    int_en = 1'b1;
    data_in = 8'h4B;
    INT = 1'b1;  // "edge 0" has just passed
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("ack_inta_e%0d", e), {31'd0, INTA_n}, expl[e]);
      chk($sformatf("ack_vvalid_e%0d", e), {31'd0, vector_valid}, (e >= 9) ? 1 : 0);
    end
    chk("ack_vector", {24'd0, vector}, 32'h4B);

    // ---------------- backpressure ----------------
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_vvalid_held", {31'd0, vector_valid}, 32'd1);
      chk("bp_no_new_inta", {31'd0, INTA_n}, 32'd1);
    end
    vector_ready = 1'b1;
    tick();
    vector_ready = 1'b0;
    chk("bp_accept", {30'd0, vector_valid, busy}, 32'b01);
    chk("bp_vector_kept", {24'd0, vector}, 32'h4B);
    tick();
    chk("bp_rec_done", {30'd0, busy, INTA_n}, 32'b01);
    tick();
    chk("bp_next_inta1", {31'd0, INTA_n}, 32'd0);
    drain("drain_bp");

    // ---------------- reset mid-INTA2 ----------------
    data_in = 8'h5A;
    INT = 1'b1;
    wait_inta(1'b0, "rmid_pulse1");
    wait_inta(1'b1, "rmid_gap");
    wait_inta(1'b0, "rmid_pulse2");
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_inta_n", {31'd0, INTA_n}, 32'd1);
    chk("rmid_vector", {23'd0, vector, vector_valid}, 32'd0);
    INT = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ---------------- EOI encoding table ----------------
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      while (eoi_ready !== 1'b1 && n < 20) begin tick(); n++; end
      chk($sformatf("eoi%0d_ready", i), {31'd0, eoi_ready}, 32'd1);
      eoi_valid = 1'b1;
      eoi_specific = tbl[i].spec;
      eoi_level = tbl[i].lvl;
      tick();
      eoi_valid = 1'b0;
      chk($sformatf("eoi%0d_strobe", i), {27'd0, WR_n, A0, data_oe, busy, eoi_ready}, 32'b00110);
      chk($sformatf("eoi%0d_data", i), {24'd0, data_out}, {24'd0, tbl[i].exp_dat});
      n = 0;
      while (WR_n === 1'b0 && n < 20) begin tick(); n++; end
      chk($sformatf("eoi%0d_wr_len", i), n, 2);
      chk($sformatf("eoi%0d_oe_off", i), {31'd0, data_oe}, 32'd0);
    end

    // ---------------- simultaneous EOI and interrupt ----------------
    int_en = 1'b0;
    INT = 1'b1;
    tick(); tick(); tick();
    eoi_valid = 1'b1;
    eoi_specific = 1'b0;
    int_en = 1'b1;
    tick();
    eoi_valid = 1'b0;
    chk("sim_e1", {30'd0, WR_n, INTA_n}, 32'b01);
    tick();
    chk("sim_e2", {30'd0, WR_n, INTA_n}, 32'b01);
    tick();
    chk("sim_rec", {29'd0, WR_n, INTA_n, busy}, 32'b111);
    tick();
    chk("sim_idle", {30'd0, INTA_n, busy}, 32'b10);
    tick();
    chk("sim_inta1", {31'd0, INTA_n}, 32'd0);
    drain("drain_sim");

    // ---------------- int_en gating ----------------
    int_en = 1'b0;
    INT = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("gate_blocked", {30'd0, INTA_n, busy}, 32'b10);
    end
    int_en = 1'b1;
    tick();
    chk("gate_release", {31'd0, INTA_n}, 32'd0);
    drain("drain_gate");

    // ---------------- randomized traffic against the monitor ----------------
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      data_in = 8'($urandom);
      vector_ready = 1'($urandom_range(0, 1));
      int_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) INT = ~INT;
      if (eoi_taken) begin
        eoi_valid = 1'b0;
        eoi_taken = 1'b0;
      end else if (!eoi_valid && $urandom_range(0, 11) == 0) begin
        eoi_valid = 1'b1;
        eoi_specific = 1'($urandom_range(0, 1));
        eoi_level = 3'($urandom_range(0, 7));
      end
    end
    drain("drain_rand");
    chk("rand_vec_q_empty", exp_vec_q.size(), 0);
    chk("rand_eoi_q_empty", exp_eoi_q.size(), 0);
    chk("rand_saw_vectors", {31'd0, n_vec > 5}, 32'd1);
    chk("rand_saw_eois", {31'd0, n_eoi > 5}, 32'd1);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
